// File: rtl/fetch.sv
// fetch: instruction fetch stage, one outstanding imem read, valid/ready to decode,
// redirect squashes wrong-path fetches.
module fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] instruction_o,
   output logic [31:0] pc_o,
   output logic        valid_o,
   input  logic        ready_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i
);
   typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;
   state_t      state, state_d;
   logic [31:0] pc_q, pc_d;
   logic        drop_q, drop_d, cap, squash;
   assign squash      = drop_q | redirect_i;
   assign imem_req_o  = (state == REQ) & !rst_i;
   assign imem_addr_o = pc_q;
   assign valid_o     = state == HOLD;
   always_comb begin
      state_d = state;
      drop_d  = drop_q;
      cap     = 1'b0;
      case (state)
         REQ:  if (imem_gnt_i) begin
                  state_d = WAIT;
                  drop_d  = redirect_i;
               end
         WAIT: if (imem_rvalid_i) begin
                  state_d = squash ? REQ : HOLD;
                  drop_d  = 1'b0;
                  cap     = !squash;
               end else if (redirect_i) drop_d = 1'b1;
         HOLD: if (ready_i | redirect_i) state_d = REQ;
         default: state_d = REQ;
      endcase
      // redirect overrides the sequential increment
      pc_d = redirect_i ? (redirect_pc_i & ~32'h3) : cap ? pc_q + 32'd4 : pc_q;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= REQ;
         pc_q          <= RESET_PC;
         drop_q        <= 1'b0;
         instruction_o <= 32'h0000_0013;
         pc_o          <= 32'h0;
      end else begin
         state  <= state_d;
         pc_q   <= pc_d;
         drop_q <= drop_d;
         if (cap) begin
            instruction_o <= imem_rdata_i;
            pc_o          <= pc_q;
         end
      end
   end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: per-cycle vector table for fetch; inputs driven at negedge, outputs checked 1ns later.
module tb_fetch;
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic        clk_i = 1'b0, rst_i = 1'b1;
   logic        imem_req_o, imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
   logic [31:0] imem_addr_o, imem_rdata_i = 32'h0;
   logic [31:0] instruction_o, pc_o;
   logic        valid_o, ready_i = 1'b0, redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'h0;
   int          total = 0, bad = 0;

   fetch dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .instruction_o(instruction_o), .pc_o(pc_o), .valid_o(valid_o),
      .ready_i(ready_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        rst, gnt, rv;
      logic [31:0] rdata;
      logic        rdy, redir;
      logic [31:0] rpc;
      logic        req;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] ins, pc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rst, logic gnt, logic rv, logic [31:0] rdata, logic rdy,
                               logic redir, logic [31:0] rpc, logic req, logic [31:0] addr,
                               logic vld, logic [31:0] ins, logic [31:0] pc);
      vec_t v;
      v.rst = rst; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy; v.redir = redir;
      v.rpc = rpc; v.req = req; v.addr = addr; v.vld = vld; v.ins = ins; v.pc = pc;
      return v;
   endfunction

   task automatic check(string name, logic req, logic [31:0] addr, logic vld,
                        logic [31:0] ins, logic [31:0] pc);
      total++;
      if ({imem_req_o, imem_addr_o, valid_o, instruction_o, pc_o} !== {req, addr, vld, ins, pc}) begin
         bad++;
         $display("FAIL %s: got req=%b addr=%h vld=%b ins=%h pc=%h, want req=%b addr=%h vld=%b ins=%h pc=%h",
                  name, imem_req_o, imem_addr_o, valid_o, instruction_o, pc_o, req, addr, vld, ins, pc);
      end
   endtask

   initial begin
      //                rst gnt rv rdata         rdy red rpc            req addr          vld ins           pc
      // sequential fetch 0,4,8,C
      vecs.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'h0,          1, 32'h0,         0, NOP,          32'h0));
      vecs.push_back(mk(0, 0, 1, 32'h1000_0000, 1, 0, 32'h0,          0, 32'h0,         0, NOP,          32'h0));
      vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,          0, 32'h4,         1, 32'h1000_0000, 32'h0));
      vecs.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'h0,          1, 32'h4,         0, 32'h1000_0000, 32'h0));
      vecs.push_back(mk(0, 0, 1, 32'h1000_0004, 1, 0, 32'h0,          0, 32'h4,         0, 32'h1000_0000, 32'h0));
      vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,          0, 32'h8,         1, 32'h1000_0004, 32'h4));
      vecs.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'h0,          1, 32'h8,         0, 32'h1000_0004, 32'h4));
      vecs.push_back(mk(0, 0, 1, 32'h1000_0008, 1, 0, 32'h0,          0, 32'h8,         0, 32'h1000_0004, 32'h4));
      vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,          0, 32'hC,         1, 32'h1000_0008, 32'h8));
      vecs.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'h0,          1, 32'hC,         0, 32'h1000_0008, 32'h8));
      vecs.push_back(mk(0, 0, 1, 32'h1000_000C, 1, 0, 32'h0,          0, 32'hC,         0, 32'h1000_0008, 32'h8));
      // decode stalls 5 cycles in HOLD
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0, 0, 0, 32'h0,      0, 0, 32'h0,          0, 32'h10,        1, 32'h1000_000C, 32'hC));
      vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,          0, 32'h10,        1, 32'h1000_000C, 32'hC));
      vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,          1, 32'h10,        0, 32'h1000_000C, 32'hC));
      vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 32'h0,          1, 32'h10,        0, 32'h1000_000C, 32'hC));
      // redirect in WAIT, late response squashed
      vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h100,        0, 32'h10,        0, 32'h1000_000C, 32'hC));
      vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,          0, 32'h100,       0, 32'h1000_000C, 32'hC));
      vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,          0, 32'h100,       0, 32'h1000_000C, 32'hC));
      vecs.push_back(mk(0, 0, 1, 32'hDEAD_BEEF, 1, 0, 32'h0,          0, 32'h100,       0, 32'h1000_000C, 32'hC));
      vecs.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'h0,          1, 32'h100,       0, 32'h1000_000C, 32'hC));
      vecs.push_back(mk(0, 0, 1, 32'h1000_0100, 1, 0, 32'h0,          0, 32'h100,       0, 32'h1000_000C, 32'hC));
      vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,          0, 32'h104,       1, 32'h1000_0100, 32'h100));
      // redirect in REQ without gnt, then redirect with gnt (target low bits masked)
      vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h40,         1, 32'h104,       0, 32'h1000_0100, 32'h100));
      vecs.push_back(mk(0, 1, 0, 32'h0,         1, 1, 32'h207,        1, 32'h40,        0, 32'h1000_0100, 32'h100));
      vecs.push_back(mk(0, 0, 1, 32'h1000_0040, 1, 0, 32'h0,          0, 32'h204,       0, 32'h1000_0100, 32'h100));
      vecs.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'h0,          1, 32'h204,       0, 32'h1000_0100, 32'h100));
      vecs.push_back(mk(0, 0, 1, 32'h1000_0204, 1, 0, 32'h0,          0, 32'h204,       0, 32'h1000_0100, 32'h100));
      // redirect in HOLD with ready
      vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 32'h300,        0, 32'h208,       1, 32'h1000_0204, 32'h204));
      vecs.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'h0,          1, 32'h300,       0, 32'h1000_0204, 32'h204));
      vecs.push_back(mk(0, 0, 1, 32'h1000_0300, 1, 0, 32'h0,          0, 32'h300,       0, 32'h1000_0204, 32'h204));
      vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,          0, 32'h304,       1, 32'h1000_0300, 32'h300));
      // redirect in WAIT with rvalid the same cycle
      vecs.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'h0,          1, 32'h304,       0, 32'h1000_0300, 32'h300));
      vecs.push_back(mk(0, 0, 1, 32'hBAD0_BAD0, 1, 1, 32'hFFFF_FFFC,  0, 32'h304,       0, 32'h1000_0300, 32'h300));
      // wrap at top of address space
      vecs.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h1000_0300, 32'h300));
      vecs.push_back(mk(0, 0, 1, 32'h1FFF_FFFC, 1, 0, 32'h0,          0, 32'hFFFF_FFFC, 0, 32'h1000_0300, 32'h300));
      vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,          0, 32'h0,         1, 32'h1FFF_FFFC, 32'hFFFF_FFFC));
      vecs.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'h0,          1, 32'h0,         0, 32'h1FFF_FFFC, 32'hFFFF_FFFC));
      vecs.push_back(mk(0, 0, 1, 32'h1000_0000, 1, 0, 32'h0,          0, 32'h0,         0, 32'h1FFF_FFFC, 32'hFFFF_FFFC));
      vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,          0, 32'h4,         1, 32'h1000_0000, 32'h0));
      // reset mid-WAIT, then stray rvalid in REQ ignored
      vecs.push_back(mk(0, 1, 0, 32'h0,         1, 0, 32'h0,          1, 32'h4,         0, 32'h1000_0000, 32'h0));
      vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,          0, 32'h4,         0, 32'h1000_0000, 32'h0));
      vecs.push_back(mk(1, 1, 0, 32'h0,         1, 0, 32'h0,          0, 32'h0,         0, NOP,          32'h0));
      vecs.push_back(mk(0, 0, 1, 32'h5555_AAAA, 1, 0, 32'h0,          1, 32'h0,         0, NOP,          32'h0));
      vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h0,         0, NOP,          32'h0));

      repeat (2) @(negedge clk_i);
      foreach (vecs[i]) begin
         @(negedge clk_i);
         rst_i = vecs[i].rst; imem_gnt_i = vecs[i].gnt; imem_rvalid_i = vecs[i].rv;
         imem_rdata_i = vecs[i].rdata; ready_i = vecs[i].rdy; redirect_i = vecs[i].redir;
         redirect_pc_i = vecs[i].rpc;
         #1 check($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].vld, vecs[i].ins, vecs[i].pc);
      end

      // latency: gnt in first REQ cycle, rvalid one cycle later -> valid two cycles after req
      begin
         int n = 0;
         @(negedge clk_i);
         rst_i = 0; ready_i = 0; redirect_i = 0; imem_rvalid_i = 0; imem_gnt_i = 1;
         @(negedge clk_i);
         imem_gnt_i = 0; imem_rvalid_i = 1; imem_rdata_i = 32'hCAFE_F00D;
         @(negedge clk_i);
         imem_rvalid_i = 0;
         while (!valid_o && n < 10) begin
            @(negedge clk_i);
            n++;
         end
         total++;
         if (n != 0) begin
            bad++;
            $display("FAIL latency: valid_o after %0d extra cycles, want 0", n);
         end
         #1 check("latency_data", 1'b0, 32'h4, 1'b1, 32'hCAFE_F00D, 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
